aes_add_round_key: RTL and testbench
====================================

Name: aes_add_round_key

Overview:
- Stage directly downstream of MixColumns in the iterative AES-128 encrypt datapath.
- XORs each incoming 128-bit state with the current round key and registers the result.
- Generates round keys on the fly (key schedule), one per accepted block, for rounds 0..10.
- Also serves round 0 (plaintext, no MixColumns) and round 10 (ShiftRows output, no MixColumns); the round controller drives the state_in source mux.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active low
- key_load  in  1  one-cycle pulse: capture key_in as cipher key, restart at round 0
- key_in  in  [0:127]  cipher key; byte 0 = bits 0:7, column-major as MixColumns
- in_valid  in  1  state_in valid
- in_ready  out  1  stage can accept state_in
- state_in  in  [0:127]  state to be keyed (same byte order)
- out_valid  out  1  state_out valid
- out_ready  in  1  consumer accepts state_out
- state_out  out  [0:127]  state_in XOR round key
- out_round  out  [3:0]  round index (0..10) of the key applied to state_out
- out_last  out  1  state_out is final ciphertext (out_round == NR)

Behaviour:
- Reset, asynchronous, active low: state_out=0, out_valid=0, out_round=0, out_last=0, in_ready=0, FSM=NOKEY, round=0, rcon=8'h01, key registers=0.
- FSM states:
  - NOKEY: in_ready=0. key_load -> RUN.
  - RUN: in_ready = !out_valid || out_ready. Remains in RUN.
  - key_load in any state reloads the key and goes to RUN.
- key_load at posedge: cipher_key <= key_in; rk <= key_in; round <= 0; rcon <= 8'h01. in_ready is forced to 0 while key_load is high, so key_load beats an in_valid in the same cycle. A pending out_valid/state_out is held unchanged, not flushed.
- Accept (in_valid && in_ready) at posedge:
  - state_out <= state_in ^ rk; out_round <= round; out_last <= (round==NR); out_valid <= 1.
  - Latency is 1 cycle, and throughput is 1 block per cycle under no backpressure.
- Key advance on accept when round < NR:
  - rk <= expand(rk, rcon); round <= round+1; rcon <= xtime(rcon), i.e. the 0x1b reduction sequence 01,02,04,08,10,20,40,80,1b,36.
- Key advance on accept when round == NR (wrap-around):
  - rk <= cipher_key; round <= 0; rcon <= 8'h01. The next block restarts at round 0 with no reload.
- expand(): words w0..w3 = rk[0:31]..rk[96:127].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord rotates bytes left by one.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - Purely combinational from registers, within the one cycle.
- Output handshake:
  - out_valid clears when out_ready && out_valid and no accept happens in the same cycle.
  - Simultaneous drain and accept keeps out_valid=1 with the new data.
  - state_out, out_round and out_last are stable while out_valid && !out_ready.
- in_valid while in NOKEY is ignored (in_ready=0). No data is lost, because the producer holds the data.
- Reset mid-stream discards the key and any pending output; a key_load is required before further traffic.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10
  - RCON_INIT=8'h01
  - xtime function, identical to the MixColumns one, with the 0x1b reduction
  - byte/word slice helpers for the [0:127] column-major layout
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational FIPS-197 S-box. Four instances implement SubWord, and the block shares this module with the SubBytes stage.
- Everything else stays in one module: FSM, round counter, rcon register, key registers and output register.

Test Plan:
- Key schedule check: key_load key_in=2b7e151628aed2a6abf7158809cf4f3c, then feed 11 zero states back-to-back with out_ready=1.
  - state_out round 1 = a0fafe1788542cb123a339392a6c7605.
  - state_out round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - out_last=1 only on the 11th output.
- Round-0 vector: same key, state_in=3243f6a8885a308d313198a2e0370734 -> state_out=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, 1 cycle after accept.
- Wrap-around: after 11 accepts, a 12th zero state -> state_out=2b7e1516...09cf4f3c, out_round=0, with no key_load issued.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly one accept, state_out stable, in_ready=0. On release, one output per cycle with rounds in order.
- Control edge cases:
  - key_load=000102030405060708090a0b0c0d0e0f in the same cycle as in_valid=1 -> no accept that cycle; next zero state gives round 0 = new key, round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - in_valid before any key_load -> in_ready=0 and no output.
- Async reset mid-stream (round 5 pending, out_ready=0): assert rst_n=0 between clock edges -> out_valid, in_ready and state_out go to 0 immediately. After release, in_ready stays 0 until key_load.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 constants, types and helpers for the
//                encrypt datapath ([0:127] column-major byte layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key-stage control state: no key loaded yet, or running rounds
    typedef enum logic [0:0] {
        ST_NOKEY = 1'b0,
        ST_RUN   = 1'b1
    } ark_state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column (32-bit word) idx of a state; word 0 holds bytes 0..3
    function automatic logic [0:31] get_word(input logic [0:127] s, input logic [1:0] idx);
        return s[{idx, 5'b00000} +: 32];
    endfunction

    // Byte idx of a state; byte 0 sits in bits 0:7
    function automatic logic [0:7] get_byte(input logic [0:127] s, input logic [3:0] idx);
        return s[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box: multiplicative inverse in
//                GF(2^8) followed by the FIPS-197 affine transform.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // GF(2^8) product by shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0 as required
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Affine map: s ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic logic [7:0] affine(input logic [7:0] s);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                 ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] w_inv;

    // Inverse then affine, purely combinational
    always_comb begin
        w_inv = gf_inv(din);
        dout  = affine(w_inv);
    end

endmodule
`default_nettype wire

// File: rtl/aes_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : aes_add_round_key
//  Description : AddRoundKey stage of the iterative AES-128 encrypt datapath.
//                XORs each accepted state with the current round key,
//                registers the result, and expands the next round key on the
//                fly (rounds 0..NR, wrapping back to the cipher key).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_add_round_key
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [0:127] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] c_nr = 4'(NR);

    ark_state_e   r_fsm;
    logic [0:127] r_cipher_key;
    logic [0:127] r_rk;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;

    logic         r_out_valid;
    logic [0:127] r_state_out;
    logic [3:0]   r_out_round;
    logic         r_out_last;

    logic         w_accept;
    logic [0:31]  w_w0, w_w1, w_w2, w_w3;
    logic [0:31]  w_rot, w_sub, w_t;
    logic [0:31]  w_n0, w_n1, w_n2, w_n3;
    logic [0:127] w_rk_next;

    // A key load owns the cycle, so it always wins over a concurrent in_valid
    assign in_ready = (r_fsm == ST_RUN) && !key_load && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Key expansion from the registered round key
    assign w_w0 = get_word(r_rk, 2'd0);
    assign w_w1 = get_word(r_rk, 2'd1);
    assign w_w2 = get_word(r_rk, 2'd2);
    assign w_w3 = get_word(r_rk, 2'd3);
    assign w_rot = {w_w3[8:31], w_w3[0:7]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .din  (w_rot[gi*8 +: 8]),
                .dout (w_sub[gi*8 +: 8])
            );
        end
    endgenerate

    assign w_t       = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    // Control state, round counter, rcon and key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= ST_NOKEY;
            r_cipher_key <= '0;
            r_rk         <= '0;
            r_round      <= 4'd0;
            r_rcon       <= RCON_INIT;
        end else if (key_load) begin
            r_fsm        <= ST_RUN;
            r_cipher_key <= key_in;
            r_rk         <= key_in;
            r_round      <= 4'd0;
            r_rcon       <= RCON_INIT;
        end else if (w_accept) begin
            if (r_round == c_nr) begin
                // Last round key used: restart from the cipher key, no reload needed
                r_rk    <= r_cipher_key;
                r_round <= 4'd0;
                r_rcon  <= RCON_INIT;
            end else begin
                r_rk    <= w_rk_next;
                r_round <= r_round + 4'd1;
                r_rcon  <= xtime(r_rcon);
            end
        end
    end

    // Output register; holds steady under backpressure, untouched by key loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_state_out <= '0;
            r_out_round <= 4'd0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_state_out <= state_in ^ r_rk;
            r_out_round <= r_round;
            r_out_last  <= (r_round == c_nr);
        end else if (out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign state_out = r_state_out;
    assign out_round = r_out_round;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_aes_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_add_round_key
//  Description : Scoreboard bench for aes_add_round_key. A table-driven
//                FIPS-197 key expansion model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_add_round_key;

    typedef struct packed {
        logic [0:127] s;
        logic [3:0]   r;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [0:127] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [0:127] state_out;
    logic [3:0]   out_round;
    logic         out_last;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    beat_t exp_q[$];
    beat_t got_q[$];

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [0:2047] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [7:0] rcon_tbl [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [0:127] m_rk [0:10];
    int           m_idx = 0;

    aes_add_round_key dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tbl[int'(x) * 8 +: 8];
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // FIPS-197 key expansion into eleven round keys
    task automatic model_load(input logic [0:127] key);
        logic [0:31] w [0:43];
        logic [0:31] t;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[8:31], t[0:7]};
                t = {sb(t[0:7]), sb(t[8:15]), sb(t[16:23]), sb(t[24:31])};
                t[0:7] = t[0:7] ^ rcon_tbl[i/4 - 1];
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        m_idx = 0;
    endtask

    // Stimulus observer: tracks key loads and accepts, predicts outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_load) begin
                chk("keyload_blocks_ready", in_ready, 0);
                model_load(key_in);
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{s: state_in ^ m_rk[m_idx], r: 4'(m_idx), l: (m_idx == 10)});
                acc_cnt++;
                m_idx = (m_idx == 10) ? 0 : m_idx + 1;
            end
        end
    end

    // Output monitor: pops and compares on every completed output transfer
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back('{s: state_out, r: out_round, l: out_last});
            if (exp_q.size() == 0) fail_now("sb_unexpected_output");
            else begin
                e = exp_q.pop_front();
                chk("sb_state", state_out, e.s);
                chk("sb_round", out_round, e.r);
                chk("sb_last", out_last, e.l);
            end
        end
    end

    task automatic send(input logic [0:127] s);
        int n = 0;
        in_valid = 1'b1;
        state_in = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) chk("send_timeout_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_key_load(input logic [0:127] k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [0:127] held;
    int           a0;
    bit           rnd_done;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_state_out", state_out, 0);
        chk("rst_out_round", out_round, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // No key yet: in_valid is ignored
        in_valid = 1'b1;
        state_in = 128'h1;
        repeat (3) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Key schedule KAT plus wrap-around
        do_key_load(FIPS_KEY);
        got_q.delete();
        for (int i = 0; i < 12; i++) send('0);
        drain();
        chk("kat_count", got_q.size(), 12);
        if (got_q.size() >= 12) begin
            chk("kat_round1", got_q[1].s, 128'ha0fafe1788542cb123a339392a6c7605);
            chk("kat_round10", got_q[10].s, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            chk("kat_last10", got_q[10].l, 1);
            chk("kat_last9", got_q[9].l, 0);
            chk("wrap_state", got_q[11].s, FIPS_KEY);
            chk("wrap_round", got_q[11].r, 0);
        end

        // Round-0 vector with one-cycle latency
        do_key_load(FIPS_KEY);
        in_valid = 1'b1;
        state_in = 128'h3243f6a8885a308d313198a2e0370734;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("r0_out_valid", out_valid, 1);
        chk("r0_state", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("r0_round", out_round, 0);
        drain();

        // Backpressure: one accept, output held, then in-order release
        out_ready = 1'b0;
        a0 = acc_cnt;
        in_valid = 1'b1;
        state_in = rand128();
        @(posedge clk); #1;
        held = state_out;
        state_in = rand128();
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_state_stable", state_out, held);
            chk("bp_out_valid", out_valid, 1);
        end
        chk("bp_accepts", acc_cnt - a0, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(state_in);
        send(rand128());
        send(rand128());
        drain();

        // key_load in the same cycle as in_valid
        got_q.delete();
        key_load = 1'b1;
        key_in   = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid = 1'b1;
        state_in = '0;
        @(negedge clk);
        chk("kl_same_cycle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) send('0);
        drain();
        chk("kl2_count", got_q.size(), 11);
        if (got_q.size() >= 11) begin
            chk("kl2_round0", got_q[0].s, 128'h000102030405060708090a0b0c0d0e0f);
            chk("kl2_round10", got_q[10].s, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        end

        // Randomised traffic with random backpressure and occasional rekeys
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    if (k % 25 == 24) do_key_load(rand128());
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(rand128());
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Asynchronous reset with round 5 pending
        do_key_load(FIPS_KEY);
        for (int i = 0; i < 5; i++) send('0);
        drain();
        out_ready = 1'b0;
        send('0);
        #2;
        chk("pre_rst_round5", out_round, 5);
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_state_out", state_out, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        state_in = '0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_in_ready", in_ready, 0);
            chk("post_rst_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_key_load(rand128());
        for (int i = 0; i < 3; i++) send(rand128());
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
